// File: rtl/vending_money_ledger_pkg.sv
// Shared sizes and FSM encodings for the vending machine money ledger.
package vending_machine_def;
    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 31;
    localparam int kWideBits  = kTotalBits + 3;

    typedef enum logic [1:0] {
        kIdle      = 2'd0,
        kCredit    = 2'd1,
        kReturning = 2'd2
    } state_e;

    typedef logic [kWideBits-1:0] wide_t;

    localparam wide_t kMaxBalance = {3'b000, {kTotalBits{1'b1}}};

    function automatic wide_t widen32(input logic [31:0] value);
        return wide_t'(value);
    endfunction
endpackage

// File: rtl/vending_money_ledger_item_selector.sv
// Combinational picker: grants the lowest-index requested item whose price fits the balance.
module item_selector
    import vending_machine_def::*;
(
    input  logic [kNumItems-1:0]    i_req,
    input  logic [32*kNumItems-1:0] i_price,
    input  logic [kWideBits-1:0]    i_balance,
    output logic [kNumItems-1:0]    o_grant,
    output logic [31:0]             o_price
);
    // Scan from the top down so the lowest affordable index is the last one written.
    always_comb begin
        o_grant = '0;
        o_price = '0;
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (i_req[i] && (widen32(i_price[32*i +: 32]) <= i_balance)) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_price    = i_price[32*i +: 32];
            end
        end
    end
endmodule

// File: rtl/vending_money_ledger.sv
// Money ledger: credits coins, debits dispensed items and returned coins, tracks the balance FSM.
module vending_money_ledger
    import vending_machine_def::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [kNumCoins-1:0]    i_input_coin,
    input  logic [kNumItems-1:0]    i_select_item,
    input  logic [kNumCoins-1:0]    i_return_coin,
    input  logic [32*kNumCoins-1:0] coin_value,
    input  logic [32*kNumItems-1:0] item_price,
    output logic [kTotalBits-1:0]   relative_money,
    output logic [kNumItems-1:0]    o_available_item,
    output logic [kNumItems-1:0]    o_output_item,
    output logic [1:0]              o_state
);
    state_e                 r_state;
    state_e                 w_next_state;
    logic [kTotalBits-1:0]  r_money;
    logic [kNumItems-1:0]   r_available;
    logic [kNumItems-1:0]   r_output_item;

    wide_t                  w_credit;
    wide_t                  w_t_credit;
    wide_t                  w_ret_value;
    wide_t                  w_t_next;
    logic                   w_return_active;
    logic [kNumItems-1:0]   w_sel_req;
    logic [kNumItems-1:0]   w_grant;
    logic [31:0]            w_sel_price;
    logic                   w_dispense;
    logic [kNumItems-1:0]   w_available_next;

    assign w_return_active = |i_return_coin;
    assign w_sel_req       = w_return_active ? '0 : i_select_item;
    assign w_dispense      = |w_grant;

    always_comb begin
        w_credit = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (i_input_coin[k]) begin
                w_credit = w_credit + widen32(coin_value[32*k +: 32]);
            end
        end
        w_t_credit = wide_t'(r_money) + w_credit;
        if (w_t_credit > kMaxBalance) begin
            w_t_credit = kMaxBalance;
        end
    end

    // Lowest set return bit wins when the timer hands us a non-one-hot mask.
    always_comb begin
        w_ret_value = '0;
        for (int k = kNumCoins - 1; k >= 0; k--) begin
            if (i_return_coin[k]) begin
                w_ret_value = widen32(coin_value[32*k +: 32]);
            end
        end
    end

    item_selector u_item_selector (
        .i_req     (w_sel_req),
        .i_price   (item_price),
        .i_balance (w_t_credit),
        .o_grant   (w_grant),
        .o_price   (w_sel_price)
    );

    always_comb begin
        if (w_return_active) begin
            w_t_next = (w_t_credit > w_ret_value) ? (w_t_credit - w_ret_value) : '0;
        end else begin
            w_t_next = w_t_credit - widen32(w_sel_price);
        end
        w_available_next = '0;
        for (int i = 0; i < kNumItems; i++) begin
            w_available_next[i] = widen32(item_price[32*i +: 32]) <= w_t_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= kIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A return episode ends only when the customer inserts money or buys something.
    always_comb begin
        w_next_state = r_state;
        if (w_t_next == '0) begin
            w_next_state = kIdle;
        end else if (w_return_active) begin
            w_next_state = kReturning;
        end else if ((r_state == kReturning) && !(|i_input_coin) && !w_dispense) begin
            w_next_state = kReturning;
        end else begin
            w_next_state = kCredit;
        end
    end

    always_comb begin
        o_state          = r_state;
        relative_money   = r_money;
        o_available_item = r_available;
        o_output_item    = r_output_item;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_money       <= '0;
            r_available   <= '0;
            r_output_item <= '0;
        end else begin
            r_money       <= w_t_next[kTotalBits-1:0];
            r_available   <= w_available_next;
            r_output_item <= w_grant;
        end
    end
endmodule

// File: tb/tb_vending_money_ledger.sv
// Self-checking bench for vending_money_ledger: directed scenarios plus randomized traffic vs a model.
module tb_vending_money_ledger;
    localparam longint kMax = (64'd1 << 31) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  i_input_coin = '0;
    logic [3:0]  i_select_item = '0;
    logic [2:0]  i_return_coin = '0;
    logic [95:0] coin_value;
    logic [127:0] item_price;
    logic [30:0] relative_money;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [1:0]  o_state;

    logic [31:0] cv [3];
    logic [31:0] pr [4];

    int errors = 0;
    int checks = 0;

    longint     m_bal;
    logic [3:0] m_out;
    logic [3:0] m_avail;
    logic [1:0] m_state;

    assign coin_value = {cv[2], cv[1], cv[0]};
    assign item_price = {pr[3], pr[2], pr[1], pr[0]};

    always #5 clk = ~clk;

    vending_money_ledger dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_return_coin    (i_return_coin),
        .coin_value       (coin_value),
        .item_price       (item_price),
        .relative_money   (relative_money),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_state          (o_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_default_values();
        cv[0] = 32'd100;  cv[1] = 32'd500;  cv[2] = 32'd1000;
        pr[0] = 32'd400;  pr[1] = 32'd500;  pr[2] = 32'd1000; pr[3] = 32'd2000;
    endtask

    task automatic model_clear();
        m_bal = 0; m_out = '0; m_avail = '0; m_state = 2'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_input_coin = '0; i_select_item = '0; i_return_coin = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive one cycle of inputs and advance the reference model by the ledger rules.
    task automatic drive(input logic [2:0] c, input logic [3:0] s, input logic [2:0] r);
        longint t;
        bit     done;
        @(negedge clk);
        i_input_coin = c; i_select_item = s; i_return_coin = r;
        t = m_bal;
        for (int k = 0; k < 3; k++) if (c[k]) t = t + longint'(cv[k]);
        if (t > kMax) t = kMax;
        m_out = '0;
        done = 1'b0;
        if (r != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (r[k] && !done) begin
                    t = t - longint'(cv[k]);
                    done = 1'b1;
                end
            end
            if (t < 0) t = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] && !done && longint'(pr[i]) <= t) begin
                    t = t - longint'(pr[i]);
                    m_out[i] = 1'b1;
                    done = 1'b1;
                end
            end
        end
        if (t == 0) m_state = 2'd0;
        else if (r != 0) m_state = 2'd2;
        else if (m_state == 2'd2 && c == 0 && m_out == 0) m_state = 2'd2;
        else m_state = 2'd1;
        m_bal = t;
        for (int i = 0; i < 4; i++) m_avail[i] = (longint'(pr[i]) <= t);
        @(posedge clk);
        #1;
        i_input_coin = '0; i_select_item = '0; i_return_coin = '0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        checks++;
        if ({relative_money, o_available_item, o_output_item, o_state} !== {31'd0, 4'b0, 4'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: got money=%0d avail=%b out=%b st=%0d, want 0 0000 0000 0",
                     relative_money, o_available_item, o_output_item, o_state);
        end
    endtask

    task automatic test_credit();
        drive(3'b100, 4'b0000, 3'b000);
        checks++;
        if ({relative_money, o_available_item, o_output_item, o_state} !== {31'd1000, 4'b0111, 4'b0000, 2'd1}) begin
            errors++;
            $display("FAIL credit_1000: got money=%0d avail=%b out=%b st=%0d, want 1000 0111 0000 1",
                     relative_money, o_available_item, o_output_item, o_state);
        end
    endtask

    task automatic test_dispense();
        drive(3'b000, 4'b0010, 3'b000);
        checks++;
        if ({relative_money, o_available_item, o_output_item, o_state} !== {31'd500, 4'b0011, 4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL dispense_item1: got money=%0d avail=%b out=%b st=%0d, want 500 0011 0010 1",
                     relative_money, o_available_item, o_output_item, o_state);
        end
        drive(3'b000, 4'b0000, 3'b000);
        checks++;
        if (o_output_item !== 4'b0000 || relative_money !== 31'd500) begin
            errors++;
            $display("FAIL dispense_pulse_width: got out=%b money=%0d, want 0000 500",
                     o_output_item, relative_money);
        end
    endtask

    task automatic test_no_dispense();
        drive(3'b000, 4'b1000, 3'b000);
        checks++;
        if (o_output_item !== 4'b0000 || relative_money !== 31'd500) begin
            errors++;
            $display("FAIL unaffordable: got out=%b money=%0d, want 0000 500", o_output_item, relative_money);
        end
        drive(3'b000, 4'b1011, 3'b000);
        checks++;
        if ({relative_money, o_available_item, o_output_item} !== {31'd100, 4'b0000, 4'b0001}) begin
            errors++;
            $display("FAIL lowest_affordable: got money=%0d avail=%b out=%b, want 100 0000 0001",
                     relative_money, o_available_item, o_output_item);
        end
    endtask

    task automatic test_return();
        repeat (4) drive(3'b001, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd500 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL return_setup: got money=%0d st=%0d, want 500 1", relative_money, o_state);
        end
        for (int n = 0; n < 6; n++) begin
            logic [30:0] exp_bal;
            logic [1:0]  exp_st;
            logic [3:0]  exp_av;
            drive(3'b000, 4'b0000, 3'b001);
            exp_bal = (n < 5) ? 31'(400 - 100 * n) : 31'd0;
            exp_st  = (n < 4) ? 2'd2 : 2'd0;
            exp_av  = (exp_bal >= 31'd400) ? 4'b0001 : 4'b0000;
            checks++;
            if ({relative_money, o_available_item, o_state} !== {exp_bal, exp_av, exp_st}) begin
                errors++;
                $display("FAIL return_pulse_%0d: got money=%0d avail=%b st=%0d, want %0d %b %0d",
                         n, relative_money, o_available_item, o_state, exp_bal, exp_av, exp_st);
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(3'b011, 4'b0000, 3'b000);
        drive(3'b001, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd700 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL sim_setup: got money=%0d st=%0d, want 700 1", relative_money, o_state);
        end
        drive(3'b010, 4'b0001, 3'b100);
        checks++;
        if ({relative_money, o_available_item, o_output_item, o_state} !== {31'd200, 4'b0000, 4'b0000, 2'd2}) begin
            errors++;
            $display("FAIL insert_return_select: got money=%0d avail=%b out=%b st=%0d, want 200 0000 0000 2",
                     relative_money, o_available_item, o_output_item, o_state);
        end
        drive(3'b000, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd200 || o_state !== 2'd2) begin
            errors++;
            $display("FAIL returning_hold: got money=%0d st=%0d, want 200 2", relative_money, o_state);
        end
        drive(3'b000, 4'b0000, 3'b011);
        checks++;
        if (relative_money !== 31'd100 || o_state !== 2'd2) begin
            errors++;
            $display("FAIL multi_hot_return: got money=%0d st=%0d, want 100 2", relative_money, o_state);
        end
        drive(3'b001, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd200 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL returning_exit: got money=%0d st=%0d, want 200 1", relative_money, o_state);
        end
    endtask

    task automatic test_back_to_back();
        drive(3'b100, 4'b0000, 3'b000);
        drive(3'b100, 4'b0000, 3'b000);
        drive(3'b000, 4'b0001, 3'b000);
        checks++;
        if ({relative_money, o_output_item} !== {31'd1800, 4'b0001}) begin
            errors++;
            $display("FAIL b2b_first: got money=%0d out=%b, want 1800 0001", relative_money, o_output_item);
        end
        drive(3'b000, 4'b0001, 3'b000);
        checks++;
        if ({relative_money, o_available_item, o_output_item} !== {31'd1400, 4'b0111, 4'b0001}) begin
            errors++;
            $display("FAIL b2b_second: got money=%0d avail=%b out=%b, want 1400 0111 0001",
                     relative_money, o_available_item, o_output_item);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'b010, 4'b0000, 3'b000);
        drive(3'b100, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd1500) begin
            errors++;
            $display("FAIL async_setup: got money=%0d, want 1500", relative_money);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({relative_money, o_available_item, o_output_item, o_state} !== {31'd0, 4'b0, 4'b0, 2'd0}) begin
            errors++;
            $display("FAIL async_reset: got money=%0d avail=%b out=%b st=%0d, want 0 0000 0000 0",
                     relative_money, o_available_item, o_output_item, o_state);
        end
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        drive(3'b001, 4'b0000, 3'b000);
        checks++;
        if (relative_money !== 31'd100 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL after_reset_insert: got money=%0d st=%0d, want 100 1", relative_money, o_state);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        cv[0] = 32'hFFFF_FFFF; cv[1] = 32'hFFFF_FFFF; cv[2] = 32'hFFFF_FFFF;
        pr[3] = 32'h8000_0000;
        drive(3'b111, 4'b0000, 3'b000);
        checks++;
        if ({relative_money, o_available_item, o_state} !== {31'h7FFF_FFFF, 4'b0111, 2'd1}) begin
            errors++;
            $display("FAIL saturate: got money=%0h avail=%b st=%0d, want 7fffffff 0111 1",
                     relative_money, o_available_item, o_state);
        end
        drive(3'b000, 4'b1000, 3'b000);
        checks++;
        if (o_output_item !== 4'b0000 || relative_money !== 31'h7FFF_FFFF) begin
            errors++;
            $display("FAIL wide_price: got out=%b money=%0h, want 0000 7fffffff", o_output_item, relative_money);
        end
        drive(3'b000, 4'b0000, 3'b001);
        checks++;
        if (relative_money !== 31'd0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL clamp_zero: got money=%0d st=%0d, want 0 0", relative_money, o_state);
        end
        drive(3'b000, 4'b0000, 3'b010);
        checks++;
        if (relative_money !== 31'd0 || o_state !== 2'd0) begin
            errors++;
            $display("FAIL return_at_zero: got money=%0d st=%0d, want 0 0", relative_money, o_state);
        end
        set_default_values();
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic [3:0] s;
        logic [2:0] r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 99) < 40) ? 3'($urandom_range(1, 7)) : 3'b000;
            s = ($urandom_range(0, 99) < 40) ? 4'($urandom_range(1, 15)) : 4'b0000;
            r = ($urandom_range(0, 99) < 25) ? 3'($urandom_range(1, 7)) : 3'b000;
            drive(c, s, r);
            checks++;
            if ({longint'(relative_money), o_available_item, o_output_item, o_state} !==
                {m_bal, m_avail, m_out, m_state}) begin
                errors++;
                $display("FAIL random_%0d: got money=%0d avail=%b out=%b st=%0d, want %0d %b %b %0d",
                         n, relative_money, o_available_item, o_output_item, o_state,
                         m_bal, m_avail, m_out, m_state);
            end
        end
    endtask

    initial begin
        set_default_values();
        model_clear();
        test_reset();
        test_credit();
        test_dispense();
        test_no_dispense();
        test_return();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
